// File: rtl/histogram_peak_finder_if.sv
// Read-port bundle between the histogram peak finder and the histogram RAM.
// master: the peak finder drives the address and enable.
// slave:  the RAM returns the addressed word.
interface histogram_peak_finder_if #(
    parameter int ADDR_W = 7,
    parameter int SIZE   = 7
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_adr;
    logic [SIZE-1:0]   rd_data;

    modport master (output rd_en, output rd_adr, input  rd_data);
    modport slave  (input  rd_en, input  rd_adr, output rd_data);
endinterface

// File: rtl/histogram_peak_finder.sv
// Histogram readout stage.
// After accumulation stops, a START request makes this block sweep every bin
// address of the histogram RAM read port. It finds the largest bin (the mode)
// and publishes its address and count with a one-cycle DONE pulse.
// Ties keep the lowest address.
// Optional feature, macro PEAK_TOTAL_EN: the total sample count is also
// accumulated and published on total_cnt. Without the macro, total_cnt is
// tied to 0 and no sum logic exists.
module histogram_peak_finder #(
    parameter  int MAX_NUMBER = 127,
    parameter  int SIZE       = 7,
    parameter  int RD_LAT     = 1,
    localparam int ADDR_W     = $clog2(MAX_NUMBER + 1)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     START,
    output logic                     BUSY,
    histogram_peak_finder_if.master  rd,
    output logic [ADDR_W-1:0]        peak_adr,
    output logic [SIZE-1:0]          peak_cnt,
    output logic [SIZE+ADDR_W-1:0]   total_cnt,
    output logic                     DONE
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] FIN   = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADR   = ADDR_W'(MAX_NUMBER);
    localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

    logic [1:0]        state;
    logic [1:0]        drain_cnt;

    // Delay line aligning each issued address with the RAM word it returns.
    logic              vld_pipe [RD_LAT];
    logic [ADDR_W-1:0] adr_pipe [RD_LAT];

    // Working results of the scan in progress.
    logic [SIZE-1:0]   work_max;
    logic [ADDR_W-1:0] work_idx;
    logic              hit;
    logic [SIZE-1:0]   max_nxt;
    logic [ADDR_W-1:0] idx_nxt;
    logic              accept;

    assign accept = (state == IDLE) && START;

    // Strictly-greater compare so that a tie never moves the index upward.
    always_comb begin
        hit = vld_pipe[RD_LAT-1] && (rd.rd_data > work_max);
        if (hit) begin
            max_nxt = rd.rd_data;
            idx_nxt = adr_pipe[RD_LAT-1];
        end else begin
            max_nxt = work_max;
            idx_nxt = work_idx;
        end
    end

`ifdef PEAK_TOTAL_EN
    logic [SIZE+ADDR_W-1:0] work_sum;
    logic [SIZE+ADDR_W-1:0] sum_nxt;

    // Zero-extended running sum; the width holds NUM_BINS full-scale bins.
    always_comb begin
        if (vld_pipe[RD_LAT-1]) begin
            sum_nxt = work_sum + {{ADDR_W{1'b0}}, rd.rd_data};
        end else begin
            sum_nxt = work_sum;
        end
    end

    // Running sum register, cleared at scan start.
    always_ff @(posedge CLK) begin
        if (RST || accept) begin
            work_sum <= '0;
        end else begin
            work_sum <= sum_nxt;
        end
    end

    // Publish the total together with the peak on the FIN-entry edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            total_cnt <= '0;
        end else if (state == DRAIN && drain_cnt == DRAIN_LAST) begin
            total_cnt <= sum_nxt;
        end else begin
            total_cnt <= total_cnt;
        end
    end
`else
    assign total_cnt = '0;
`endif

    // Shift {rd_en, rd_adr} through RD_LAT stages to match the RAM latency.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_pipe[i] <= 1'b0;
                adr_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0] <= rd.rd_en;
            adr_pipe[0] <= rd.rd_adr;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                adr_pipe[i] <= adr_pipe[i-1];
            end
        end
    end

    // Working max and index: cleared at scan start, otherwise follow the compare.
    always_ff @(posedge CLK) begin
        if (RST || accept) begin
            work_max <= '0;
            work_idx <= '0;
        end else begin
            work_max <= max_nxt;
            work_idx <= idx_nxt;
        end
    end

    // Scan sequencer: address sweep, drain of in-flight words, result publish.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            drain_cnt <= 2'd0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            rd.rd_en  <= 1'b0;
            rd.rd_adr <= '0;
            peak_adr  <= '0;
            peak_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        state     <= SCAN;
                        rd.rd_adr <= '0;
                        rd.rd_en  <= 1'b1;
                        BUSY      <= 1'b1;
                    end
                end
                SCAN: begin
                    if (rd.rd_adr == LAST_ADR) begin
                        rd.rd_en  <= 1'b0;
                        drain_cnt <= 2'd0;
                        state     <= DRAIN;
                    end else begin
                        rd.rd_adr <= rd.rd_adr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        // The final word is compared on this very edge, so
                        // publish the next-state values, not the registers.
                        peak_adr <= idx_nxt;
                        peak_cnt <= max_nxt;
                        DONE     <= 1'b1;
                        state    <= FIN;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                FIN: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    BUSY     <= 1'b0;
                    DONE     <= 1'b0;
                    rd.rd_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_histogram_peak_finder.sv
// Directed bench for histogram_peak_finder.
// Three DUTs run side by side with RD_LAT = 1, 2 and 3. They share one RAM
// image, and each has its own read-latency model. The expected values are
// hand-computed for each histogram image.
module tb_histogram_peak_finder;

`ifdef PEAK_TOTAL_EN
    localparam bit TOT_EN = 1'b1;
`else
    localparam bit TOT_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST;
    logic START;
    always #5 CLK = ~CLK;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    // Cycle counter used to time DONE relative to the START-accept edge.
    always @(posedge CLK) cyc <= cyc + 1;

    logic [6:0] mem [128];

    histogram_peak_finder_if #(.ADDR_W(7), .SIZE(7)) if1 ();
    histogram_peak_finder_if #(.ADDR_W(7), .SIZE(7)) if2 ();
    histogram_peak_finder_if #(.ADDR_W(7), .SIZE(7)) if3 ();

    logic busy1, busy2, busy3, done1, done2, done3;
    logic [6:0]  pa1, pa2, pa3, pc1, pc2, pc3;
    logic [13:0] tc1, tc2, tc3;

    histogram_peak_finder #(.MAX_NUMBER(127), .SIZE(7), .RD_LAT(1)) dut1 (
        .CLK(CLK), .RST(RST), .START(START), .BUSY(busy1), .rd(if1.master),
        .peak_adr(pa1), .peak_cnt(pc1), .total_cnt(tc1), .DONE(done1));
    histogram_peak_finder #(.MAX_NUMBER(127), .SIZE(7), .RD_LAT(2)) dut2 (
        .CLK(CLK), .RST(RST), .START(START), .BUSY(busy2), .rd(if2.master),
        .peak_adr(pa2), .peak_cnt(pc2), .total_cnt(tc2), .DONE(done2));
    histogram_peak_finder #(.MAX_NUMBER(127), .SIZE(7), .RD_LAT(3)) dut3 (
        .CLK(CLK), .RST(RST), .START(START), .BUSY(busy3), .rd(if3.master),
        .peak_adr(pa3), .peak_cnt(pc3), .total_cnt(tc3), .DONE(done3));

    // RAM read models with 1, 2 and 3 registered stages.
    logic [6:0] r1_0, r2_0, r2_1, r3_0, r3_1, r3_2;
    always @(posedge CLK) begin
        r1_0 <= mem[if1.rd_adr];
        r2_0 <= mem[if2.rd_adr]; r2_1 <= r2_0;
        r3_0 <= mem[if3.rd_adr]; r3_1 <= r3_0; r3_2 <= r3_1;
    end
    assign if1.rd_data = r1_0;
    assign if2.rd_data = r2_1;
    assign if3.rd_data = r3_2;

    // Event monitors: DONE pulse counts and timing, address sweep order.
    int done_cnt1 = 0, done_cnt2 = 0, done_cnt3 = 0;
    int done_cyc1 = -1, done_cyc2 = -1, done_cyc3 = -1;
    int rden_cnt1 = 0, sweep_err1 = 0;
    logic [6:0] exp_sweep1 = 7'd0;
    always @(negedge CLK) begin
        if (done1 === 1'b1) begin done_cnt1++; done_cyc1 = cyc; end
        if (done2 === 1'b1) begin done_cnt2++; done_cyc2 = cyc; end
        if (done3 === 1'b1) begin done_cnt3++; done_cyc3 = cyc; end
        if (if1.rd_en === 1'b1) begin
            rden_cnt1++;
            if (if1.rd_adr !== exp_sweep1) sweep_err1++;
            exp_sweep1 = exp_sweep1 + 7'd1;
        end else begin
            exp_sweep1 = 7'd0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_peak();
        for (int i = 0; i < 128; i++) mem[i] = 7'd0;
        mem[37] = 7'd5;
        mem[90] = 7'd12;
    endtask

    task automatic load_tie();
        for (int i = 0; i < 128; i++) mem[i] = 7'd1;
        mem[10]  = 7'd127;
        mem[64]  = 7'd127;
        mem[127] = 7'd127;
    endtask

    task automatic load_zero();
        for (int i = 0; i < 128; i++) mem[i] = 7'd0;
    endtask

    // One full scan on all three DUTs. With poke set, the published outputs
    // are checked mid-scan and START is pulsed again (it must be ignored).
    task automatic scan(input string tag, input logic [6:0] ea, input logic [6:0] ec,
                        input logic [13:0] et, input bit poke,
                        input logic [6:0] pa_prev, input logic [6:0] pc_prev);
        int k, b1, b2, b3, r1, s1, n;
        logic [13:0] etot;
        etot = TOT_EN ? et : 14'd0;
        b1 = done_cnt1; b2 = done_cnt2; b3 = done_cnt3;
        r1 = rden_cnt1; s1 = sweep_err1;
        @(negedge CLK); START = 1'b1;
        @(posedge CLK); #1 k = cyc;
        chk({tag, "_busy_at_accept"}, busy1, 1);
        @(negedge CLK); START = 1'b0;
        if (poke) begin
            repeat (50) @(negedge CLK);
            chk({tag, "_held_adr"}, pa1, pa_prev);
            chk({tag, "_held_cnt"}, pc1, pc_prev);
            START = 1'b1;
            @(negedge CLK); START = 1'b0;
        end
        n = 0;
        while (done_cnt3 == b3 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        repeat (3) @(negedge CLK);
        chk({tag, "_done1_count"}, done_cnt1 - b1, 1);
        chk({tag, "_done2_count"}, done_cnt2 - b2, 1);
        chk({tag, "_done3_count"}, done_cnt3 - b3, 1);
        chk({tag, "_done1_time"}, done_cyc1, k + 129);
        chk({tag, "_done2_time"}, done_cyc2, k + 130);
        chk({tag, "_done3_time"}, done_cyc3, k + 131);
        chk({tag, "_adr1"}, pa1, ea);
        chk({tag, "_cnt1"}, pc1, ec);
        chk({tag, "_tot1"}, tc1, etot);
        chk({tag, "_adr2"}, pa2, ea);
        chk({tag, "_cnt2"}, pc2, ec);
        chk({tag, "_tot2"}, tc2, etot);
        chk({tag, "_adr3"}, pa3, ea);
        chk({tag, "_cnt3"}, pc3, ec);
        chk({tag, "_tot3"}, tc3, etot);
        chk({tag, "_busy_after"}, busy1, 0);
        chk({tag, "_done_low"}, done1, 0);
        chk({tag, "_rden_cycles"}, rden_cnt1 - r1, 128);
        chk({tag, "_sweep_order"}, sweep_err1 - s1, 0);
    endtask

    initial begin
        int b1, b2, b3, n;
        RST   = 1'b1;
        START = 1'b0;
        load_zero();

        // Reset held 3 cycles, then idle with no START.
        repeat (3) @(posedge CLK);
        @(negedge CLK); RST = 1'b0;
        repeat (10) @(negedge CLK);
        chk("rst_busy",   busy1, 0);
        chk("rst_done",   done1, 0);
        chk("rst_rden",   if1.rd_en, 0);
        chk("rst_rdadr",  if1.rd_adr, 0);
        chk("rst_padr",   pa1, 0);
        chk("rst_pcnt",   pc1, 0);
        chk("rst_tot",    tc1, 0);
        chk("rst_rden3",  if3.rd_en, 0);
        chk("idle_rden_count", rden_cnt1, 0);
        chk("idle_done_count", done_cnt1 + done_cnt2 + done_cnt3, 0);

        // Single peak: 5 at bin 37, 12 at bin 90.
        load_peak();
        scan("peak", 7'd90, 7'd12, 14'd17, 1'b0, 7'd0, 7'd0);

        // Three-way tie at full scale, rest 1: lowest address wins.
        load_tie();
        scan("tie", 7'd10, 7'd127, 14'd506, 1'b0, 7'd0, 7'd0);

        // START while busy is ignored; published tie results hold mid-scan.
        load_peak();
        scan("busy_start", 7'd90, 7'd12, 14'd17, 1'b1, 7'd10, 7'd127);

        // All-zero histogram.
        load_zero();
        scan("zero", 7'd0, 7'd0, 14'd0, 1'b0, 7'd0, 7'd0);

        // Reset in the middle of a scan, at rd_adr == 50.
        load_tie();
        b1 = done_cnt1; b2 = done_cnt2; b3 = done_cnt3;
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        n = 0;
        while (if1.rd_adr !== 7'd50 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("midrst_reached_50", if1.rd_adr, 50);
        RST = 1'b1;
        @(negedge CLK); RST = 1'b0;
        repeat (200) @(negedge CLK);
        chk("midrst_no_done1", done_cnt1 - b1, 0);
        chk("midrst_no_done2", done_cnt2 - b2, 0);
        chk("midrst_no_done3", done_cnt3 - b3, 0);
        chk("midrst_busy",  busy1, 0);
        chk("midrst_rden",  if1.rd_en, 0);
        chk("midrst_padr",  pa1, 0);
        chk("midrst_pcnt",  pc1, 0);
        chk("midrst_tot",   tc1, 0);
        chk("midrst_padr3", pa3, 0);

        // A fresh scan after the abort completes normally.
        load_peak();
        scan("after_rst", 7'd90, 7'd12, 14'd17, 1'b0, 7'd0, 7'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/histogram_peak_finder.md
Name: histogram_peak_finder

Overview:
- Downstream readout stage for the histogram accumulator.
- After accumulation stops, it sweeps every bin address through the histogram RAM read port and tracks the largest count and the address of that bin (the mode).
- Optionally, it also accumulates the total sample count.
- It publishes the results with a one-cycle DONE pulse to the display/report logic.

Parameters:
- MAX_NUMBER, 127: highest bin address. Bins scanned are 0..MAX_NUMBER; NUM_BINS = MAX_NUMBER+1.
- SIZE, 7: width of one bin count, matching the accumulator RAM word.
- RD_LAT, 1: RAM read latency in CLK cycles, from rd_adr to rd_data valid. Legal range 1..3.
- Derived localparam ADDR_W = $clog2(MAX_NUMBER+1), which is 7 at the default.

Ports:
- CLK  in  1  single clock; all state on posedge.
- RST  in  1  synchronous active-high reset.
- START  in  1  request a scan; sampled only in IDLE.
- BUSY  out  1  high from the START-accept edge until the DONE cycle ends.
- rd_en  out  1  high while a valid address is on rd_adr.
- rd_adr  out  ADDR_W  bin address to the histogram RAM.
- rd_data  in  SIZE  RAM word; it corresponds to the rd_adr issued RD_LAT cycles earlier.
- peak_adr  out  ADDR_W  address of the largest bin from the last completed scan.
- peak_cnt  out  SIZE  count of that bin.
- total_cnt  out  SIZE+ADDR_W  sum of all bins. Tied to 0 when the optional feature is off.
- DONE  out  1  one-cycle pulse when the results update.

Behaviour:
- Reset (RST=1 at an edge):
  - state goes to IDLE;
  - BUSY, rd_en and DONE = 0;
  - rd_adr, peak_adr, peak_cnt and total_cnt = 0;
  - working registers and the valid pipeline are cleared.
  - RST overrides START in the same cycle.
- FSM states: IDLE, SCAN, DRAIN, FIN.
- IDLE → SCAN on the edge where START=1.
  - At that edge: rd_adr=0, rd_en=1, BUSY=1, working max=0, working index=0, working sum=0.
- SCAN:
  - rd_adr increments by 1 each cycle.
  - When rd_adr==MAX_NUMBER at an edge, go to DRAIN with rd_en=0 and rd_adr held.
  - No wrap: the address never passes MAX_NUMBER.
- DRAIN: lasts exactly RD_LAT cycles, collecting the last words, then goes to FIN.
- FIN:
  - Entered on the edge that also loads peak_adr, peak_cnt and total_cnt from the working registers.
  - DONE=1 and BUSY=1 for this single cycle, then back to IDLE.
- Valid pipeline:
  - An RD_LAT-deep shift register of {rd_en, rd_adr} aligns each address with its rd_data.
  - A compare/accumulate happens only when the delayed valid bit is 1.
- Compare rule:
  - Update the working max only when rd_data is strictly greater than the working max.
  - Ties therefore keep the lowest address.
  - An all-zero histogram gives peak_adr=0, peak_cnt=0.
- Sum: working sum += rd_data, zero-extended. The width SIZE+ADDR_W cannot overflow (NUM_BINS × (2^SIZE−1)).
- Latency: with START accepted at edge k, DONE is high in the cycle following edge k+NUM_BINS+RD_LAT. At defaults that is edge k+129.
- Outputs are stable between DONE pulses. A scan in progress does not disturb the published results.
- START while BUSY is ignored; it is not queued.
- START held high continuously re-triggers on the edge after FIN, because IDLE accepts it immediately.
- RST mid-scan:
  - abort immediately to the reset state;
  - no DONE;
  - published outputs clear to 0.
- The block never writes the RAM. The accumulator must be held off (its ENA=0) while BUSY=1; this is a system-level requirement.

Optional Feature:
- Macro: PEAK_TOTAL_EN.
- Defined: the working sum register and total_cnt are implemented as described above.
- Undefined: no sum logic is synthesized; total_cnt is constant 0. All other behaviour and timing are identical.

Test Plan:
- Reset then idle: apply RST 3 cycles, no START → all outputs 0, rd_en never asserts.
- Single peak (model RAM, RD_LAT=1): bin 37=5, bin 90=12, rest 0; pulse START → rd_adr sweeps 0..127, DONE 129 cycles after accept, peak_adr=90, peak_cnt=12, total_cnt=17 (0 without PEAK_TOTAL_EN).
- Tie: bins 10, 64 and 127 all =127, rest 1 → peak_adr=10, peak_cnt=127, total_cnt=506.
- Latency sweep: repeat the single-peak case with RD_LAT=2 and 3 → identical results, DONE at k+130 and k+131 respectively.
- START while busy plus all-zero histogram: pulse START again mid-scan → ignored, exactly one DONE. Next scan of an all-zero RAM → peak_adr=0, peak_cnt=0, total_cnt=0.
- Reset mid-scan: RST at rd_adr=50 → no DONE, outputs 0, BUSY=0. A new START completes normally with correct results.
